mod_voice_ctrl: RTL and testbench

//  Per-voice controller sequencing the additive sine synth datapath (4 harmonic sines + output attenuator).
//  - Accepts note commands over valid/ready and generates the free-running sample time.
//  - Holds period and harmonic attenuations; runs an ADSR envelope that drives the output attenuation.
//  - Sits between the note/MIDI front end and one synth voice; one instance per voice.

---
 rtl/mod_synth_pkg.sv | 29 ++
 rtl/mod_env_step.sv | 38 +++
 rtl/mod_voice_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mod_voice_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_synth_pkg.sv
// -----------------------------------------------------------------------------
// mod_synth_pkg
// Shared types and constants for the additive sine synth voice controller.
//   env_state_e : ADSR envelope state encoding (also exported on o_state)
//   LEVEL_W     : width of the envelope level presented to the output attenuator
//   LEVEL_MAX_DEF : envelope full scale, signed Q1.15 +1.0
//   harm_t      : four signed 16-bit harmonic weights, packed {a4,a3,a2,a1}
// -----------------------------------------------------------------------------
package mod_synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

    localparam int LEVEL_W       = 16;
    localparam int LEVEL_MAX_DEF = 32767;

    typedef struct packed {
        logic signed [LEVEL_W-1:0] a4;
        logic signed [LEVEL_W-1:0] a3;
        logic signed [LEVEL_W-1:0] a2;
        logic signed [LEVEL_W-1:0] a1;
    } harm_t;

endpackage

// File: rtl/mod_env_step.sv
// -----------------------------------------------------------------------------
// mod_env_step
// Combinational envelope step: level +/- step, clamped at a bound.
//   level_i   : current level, 17-bit signed
//   step_i    : unsigned step magnitude
//   sub_i     : 1 = subtract step (bound is a floor), 0 = add (bound is a ceiling)
//   bound_i   : ceiling (add) or floor (sub)
//   level_o   : stepped level, equal to bound_i once the bound is reached
//   reached_o : bound reached or step is zero (segment finishes this tick)
// -----------------------------------------------------------------------------
module mod_env_step
    import mod_synth_pkg::*;
(
    input  logic signed [LEVEL_W:0]   level_i,
    input  logic        [LEVEL_W-1:0] step_i,
    input  logic                      sub_i,
    input  logic signed [LEVEL_W:0]   bound_i,
    output logic signed [LEVEL_W:0]   level_o,
    output logic                      reached_o
);

    // One extra bit of headroom so level +/- a full 16-bit step never wraps.
    logic signed [LEVEL_W+1:0] ext_level;
    logic signed [LEVEL_W+1:0] ext_step;
    logic signed [LEVEL_W+1:0] ext_bound;
    logic signed [LEVEL_W+1:0] sum;

    always_comb begin
        ext_level = {level_i[LEVEL_W], level_i};
        ext_step  = $signed({2'b00, step_i});
        ext_bound = {bound_i[LEVEL_W], bound_i};
        sum       = sub_i ? (ext_level - ext_step) : (ext_level + ext_step);
        // A zero step would stall the segment forever, so it jumps straight to the bound.
        reached_o = (step_i == '0) || (sub_i ? (sum <= ext_bound) : (sum >= ext_bound));
        level_o   = reached_o ? bound_i : sum[LEVEL_W:0];
    end

endmodule

// File: rtl/mod_voice_ctrl.sv
// -----------------------------------------------------------------------------
// mod_voice_ctrl
// Per-voice controller for the additive sine synth: accepts note-on commands,
// runs the free-running sample time, holds period / harmonic weights and runs
// an ADSR envelope that drives the output attenuation.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_sample_tick         one strobe per audio sample; envelope/time advance on it
//   i_note_valid/o_note_ready, i_note_period, i_note_harm   note-on command
//   i_note_off            note-off pulse
//   i_attack_step, i_decay_step, i_sustain_level, i_release_step   ADSR settings
//   o_time                sample time, cleared on note-on from IDLE
//   o_period, o_atten1..4 synth period and harmonic weights
//   o_atten_out           envelope level to the output attenuator
//   o_active, o_state     envelope status
//
// Build option
//   MOD_VOICE_CTRL_GLIDE_EN : retriggers from a sounding note glide the period
//   towards the new value by (target-period)>>>GLIDE_SHIFT per tick instead of
//   jumping. Without it the period loads immediately on every note-on.
// -----------------------------------------------------------------------------
module mod_voice_ctrl
    import mod_synth_pkg::*;
#(
    parameter int TIME_W    = 64,
    parameter int LEVEL_MAX = LEVEL_MAX_DEF
`ifdef MOD_VOICE_CTRL_GLIDE_EN
    ,
    parameter int GLIDE_SHIFT = 4
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_sample_tick,
    input  logic                      i_note_valid,
    output logic                      o_note_ready,
    input  logic [31:0]               i_note_period,
    input  logic [63:0]               i_note_harm,
    input  logic                      i_note_off,
    input  logic [15:0]               i_attack_step,
    input  logic [15:0]               i_decay_step,
    input  logic [15:0]               i_sustain_level,
    input  logic [15:0]               i_release_step,
    output logic [TIME_W-1:0]         o_time,
    output logic [31:0]               o_period,
    output logic signed [15:0]        o_atten1,
    output logic signed [15:0]        o_atten2,
    output logic signed [15:0]        o_atten3,
    output logic signed [15:0]        o_atten4,
    output logic signed [15:0]        o_atten_out,
    output logic                      o_active,
    output logic [2:0]                o_state
);

    localparam logic signed [LEVEL_W:0] LVL_MAX_S = 17'(LEVEL_MAX);
    localparam logic [TIME_W-1:0]       TIME_ONE  = 1;

    env_state_e               state_q;
    logic signed [LEVEL_W:0]  level_q;
    logic [TIME_W-1:0]        time_q;
    logic [TIME_W-1:0]        time_d;
    logic [31:0]              period_q;
    harm_t                    harm_q;

    logic                     accept;
    logic                     note_off_ok;
    logic signed [LEVEL_W:0]  sus_lvl;
    logic [15:0]              step_amt;
    logic                     step_sub;
    logic signed [LEVEL_W:0]  step_bound;
    logic signed [LEVEL_W:0]  step_level;
    logic                     step_reached;

    assign o_note_ready = !i_rst;
    assign accept       = i_note_valid && o_note_ready;
    // Note-off only matters while the note is still sounding its A/D/S part.
    assign note_off_ok  = i_note_off && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN);
    assign time_d       = time_q + TIME_ONE;
    assign sus_lvl      = (i_sustain_level > 16'(LEVEL_MAX)) ? LVL_MAX_S
                                                             : $signed({1'b0, i_sustain_level});

    // Single shared stepper: ATTACK climbs to full scale, DECAY falls to sustain,
    // everything else falls to zero with the release step.
    always_comb begin
        step_sub   = 1'b1;
        step_amt   = i_release_step;
        step_bound = '0;
        case (state_q)
            ATTACK: begin
                step_sub   = 1'b0;
                step_amt   = i_attack_step;
                step_bound = LVL_MAX_S;
            end
            DECAY: begin
                step_amt   = i_decay_step;
                step_bound = sus_lvl;
            end
            default: ;
        endcase
    end

    mod_env_step u_env_step (
        .level_i   (level_q),
        .step_i    (step_amt),
        .sub_i     (step_sub),
        .bound_i   (step_bound),
        .level_o   (step_level),
        .reached_o (step_reached)
    );

`ifdef MOD_VOICE_CTRL_GLIDE_EN
    localparam logic signed [32:0] GLIDE_LIM = 33'sd1 <<< GLIDE_SHIFT;

    logic [31:0]        target_q;
    logic signed [32:0] glide_diff;
    logic signed [32:0] glide_move;
    logic               glide_snap;

    assign glide_diff = $signed({1'b0, target_q}) - $signed({1'b0, period_q});
    assign glide_move = glide_diff >>> GLIDE_SHIFT;
    // Within one shift quantum the arithmetic step would stall short of target.
    assign glide_snap = (glide_diff < GLIDE_LIM) && (glide_diff > -GLIDE_LIM);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            time_q   <= '0;
            period_q <= '0;
            harm_q   <= '0;
`ifdef MOD_VOICE_CTRL_GLIDE_EN
            target_q <= '0;
`endif
        end else if (accept) begin
            // Retrigger keeps the current level and, unless idle, the running phase.
            state_q <= ATTACK;
            harm_q  <= harm_t'(i_note_harm);
            if (state_q == IDLE) begin
                time_q <= '0;
            end else if (i_sample_tick) begin
                time_q <= time_d;
            end
`ifdef MOD_VOICE_CTRL_GLIDE_EN
            target_q <= i_note_period;
            if (state_q == IDLE) begin
                period_q <= i_note_period;
            end
`else
            period_q <= i_note_period;
`endif
        end else begin
            if (i_sample_tick && state_q != IDLE) begin
                time_q <= time_d;
            end
`ifdef MOD_VOICE_CTRL_GLIDE_EN
            if (i_sample_tick) begin
                period_q <= glide_snap ? target_q : (period_q + 32'(glide_move));
            end
`endif
            if (note_off_ok) begin
                // First release step waits for the following tick.
                state_q <= RELEASE;
            end else if (i_sample_tick) begin
                case (state_q)
                    IDLE: level_q <= '0;
                    ATTACK: begin
                        level_q <= step_level;
                        if (step_reached) state_q <= DECAY;
                    end
                    DECAY: begin
                        level_q <= step_level;
                        if (step_reached) state_q <= SUSTAIN;
                    end
                    SUSTAIN: level_q <= sus_lvl;
                    RELEASE: begin
                        level_q <= step_level;
                        if (step_reached) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_time      = time_q;
    assign o_period    = period_q;
    assign o_atten1    = harm_q.a1;
    assign o_atten2    = harm_q.a2;
    assign o_atten3    = harm_q.a3;
    assign o_atten4    = harm_q.a4;
    assign o_atten_out = level_q[LEVEL_W-1:0];
    assign o_active    = (state_q != IDLE);
    assign o_state     = state_q;

endmodule

// File: tb/tb_mod_voice_ctrl.sv
module tb_mod_voice_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, nv, off;
    logic [31:0] per;
    logic [63:0] harm;
    logic [15:0] atk, dec, sus, rel;

    logic        o_note_ready, o_active;
    logic [63:0] o_time;
    logic [31:0] o_period;
    logic [15:0] o_atten1, o_atten2, o_atten3, o_atten4, o_atten_out;
    logic [2:0]  o_state;

    mod_voice_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_sample_tick   (tick),
        .i_note_valid    (nv),
        .o_note_ready    (o_note_ready),
        .i_note_period   (per),
        .i_note_harm     (harm),
        .i_note_off      (off),
        .i_attack_step   (atk),
        .i_decay_step    (dec),
        .i_sustain_level (sus),
        .i_release_step  (rel),
        .o_time          (o_time),
        .o_period        (o_period),
        .o_atten1        (o_atten1),
        .o_atten2        (o_atten2),
        .o_atten3        (o_atten3),
        .o_atten4        (o_atten4),
        .o_atten_out     (o_atten_out),
        .o_active        (o_active),
        .o_state         (o_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // Behavioural reference: envelope phases 0=idle 1=attack 2=decay 3=sustain 4=release
    int          m_state;
    int          m_level;
    logic [63:0] m_time;
    logic [31:0] m_period;
    logic [63:0] m_harm;

    task automatic model_step();
        int s;
        s = (int'(sus) > 32767) ? 32767 : int'(sus);
        if (rst) begin
            m_state = 0; m_level = 0; m_time = 0; m_period = 0; m_harm = 0;
            return;
        end
        if (nv) begin
            if (m_state == 0) m_time = 0;
            else if (tick) m_time = m_time + 1;
            m_state  = 1;
            m_period = per;
            m_harm   = harm;
        end else begin
            if (tick && m_state != 0) m_time = m_time + 1;
            if (off && m_state >= 1 && m_state <= 3) begin
                m_state = 4;
            end else if (tick) begin
                case (m_state)
                    0: m_level = 0;
                    1: if (atk == 0 || m_level + int'(atk) >= 32767) begin
                           m_level = 32767; m_state = 2;
                       end else m_level = m_level + int'(atk);
                    2: if (dec == 0 || m_level - int'(dec) <= s) begin
                           m_level = s; m_state = 3;
                       end else m_level = m_level - int'(dec);
                    3: m_level = s;
                    4: if (rel == 0 || m_level - int'(rel) <= 0) begin
                           m_level = 0; m_state = 0;
                       end else m_level = m_level - int'(rel);
                    default: ;
                endcase
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready",  64'(o_note_ready), 64'(!rst));
            check("state",  64'(o_state),      64'(m_state));
            check("active", 64'(o_active),     64'(m_state != 0));
            check("level",  64'(o_atten_out),  64'(m_level));
            check("time",   o_time,            m_time);
            check("period", 64'(o_period),     64'(m_period));
            check("atten1", 64'(o_atten1),     64'(m_harm[15:0]));
            check("atten2", 64'(o_atten2),     64'(m_harm[31:16]));
            check("atten3", 64'(o_atten3),     64'(m_harm[47:32]));
            check("atten4", 64'(o_atten4),     64'(m_harm[63:48]));
        end
    end

    task automatic apply(input bit tk, input bit v, input bit of);
        tick = tk; nv = v; off = of;
        @(posedge clk); #1;
        tick = 1'b0; nv = 1'b0; off = 1'b0;
    endtask

    function automatic logic [15:0] pick_step();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return 16'd0;
        if (r <= 3) return 16'($urandom_range(1, 2000));
        if (r == 4) return 16'($urandom_range(2000, 40000));
        return 16'hFFFF;
    endfunction

    int lvl_a[8] = '{8192, 16384, 24576, 32767, 28671, 24575, 20479, 16384};
    int st_a[8]  = '{1, 1, 1, 2, 2, 2, 2, 3};
    int lvl_r[4] = '{12288, 8192, 4096, 0};
    int st_r[4]  = '{4, 4, 4, 0};
    int lvl_d[4] = '{28671, 24575, 20479, 16384};

    initial begin
        rst = 1'b1; tick = 1'b0; nv = 1'b0; off = 1'b0;
        per = 32'd100; harm = 64'hFFF0_1234_8000_7FFF;
        atk = 16'd8192; dec = 16'd4096; sus = 16'd16384; rel = 16'd4096;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        check("lit_rst_ready_low", 64'(o_note_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("lit_rst_state", 64'(o_state), 64'd0);
        check("lit_rst_ready", 64'(o_note_ready), 64'd1);
        check("lit_rst_level", 64'(o_atten_out), 64'd0);

        // Note-on from idle, then ticks every 4 clocks through attack/decay
        apply(0, 1, 0);
        check("lit_on_state", 64'(o_state), 64'd1);
        check("lit_on_period", 64'(o_period), 64'd100);
        check("lit_on_time", o_time, 64'd0);
        check("lit_on_a1", 64'(o_atten1), 64'h7FFF);
        check("lit_on_a4", 64'(o_atten4), 64'hFFF0);
        for (int k = 0; k < 8; k++) begin
            apply(1, 0, 0);
            check("lit_ad_level", 64'(o_atten_out), 64'(lvl_a[k]));
            check("lit_ad_state", 64'(o_state), 64'(st_a[k]));
            check("lit_ad_time", o_time, 64'(k + 1));
            repeat (3) apply(0, 0, 0);
        end

        // Note-off in sustain, then release to idle
        apply(0, 0, 1);
        check("lit_off_state", 64'(o_state), 64'd4);
        check("lit_off_level", 64'(o_atten_out), 64'd16384);
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 0);
            check("lit_rel_level", 64'(o_atten_out), 64'(lvl_r[k]));
            check("lit_rel_state", 64'(o_state), 64'(st_r[k]));
            repeat (3) apply(0, 0, 0);
        end
        apply(1, 0, 0);
        check("lit_idle_time_hold", o_time, 64'd12);

        // Zero attack step jumps to full scale on the first tick
        atk = 16'd0;
        apply(0, 1, 0);
        check("lit_z_time_clr", o_time, 64'd0);
        apply(1, 0, 0);
        check("lit_z_atk_level", 64'(o_atten_out), 64'd32767);
        check("lit_z_atk_state", 64'(o_state), 64'd2);
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 0);
            check("lit_z_dec_level", 64'(o_atten_out), 64'(lvl_d[k]));
        end
        check("lit_z_sus_state", 64'(o_state), 64'd3);

        // Accept and note-off together: accept wins, phase continues
        per = 32'd2000;
        apply(0, 1, 1);
        check("lit_both_state", 64'(o_state), 64'd1);
        check("lit_both_period", 64'(o_period), 64'd2000);
        check("lit_both_time", o_time, 64'd5);
        check("lit_both_level", 64'(o_atten_out), 64'd16384);

        // Zero release step drops to idle on the first tick
        apply(1, 0, 0);
        rel = 16'd0;
        apply(0, 0, 1);
        apply(1, 0, 0);
        check("lit_z_rel_state", 64'(o_state), 64'd0);
        check("lit_z_rel_level", 64'(o_atten_out), 64'd0);
        check("lit_z_rel_time", o_time, 64'd7);

        // Reset while sustaining: everything back to zero, no release tail
        atk = 16'd8192; rel = 16'd4096;
        apply(0, 1, 0);
        repeat (8) apply(1, 0, 0);
        check("lit_pre_rst_state", 64'(o_state), 64'd3);
        rst = 1'b1;
        apply(0, 0, 0);
        check("lit_mid_rst_state", 64'(o_state), 64'd0);
        check("lit_mid_rst_level", 64'(o_atten_out), 64'd0);
        check("lit_mid_rst_time", o_time, 64'd0);
        check("lit_mid_rst_period", 64'(o_period), 64'd0);
        check("lit_mid_rst_a1", 64'(o_atten1), 64'd0);
        rst = 1'b0;

        // Randomised traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                atk = pick_step();
                dec = pick_step();
                rel = pick_step();
                sus = 16'($urandom_range(0, 65535));
            end
            per  = $urandom;
            harm = {$urandom, $urandom};
            rst  = ($urandom_range(0, 599) == 0);
            nv   = ($urandom_range(0, 39) == 0);
            off  = ($urandom_range(0, 24) == 0);
            tick = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; nv = 1'b0; off = 1'b0; tick = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
